pingpong_unpack_ctrl: RTL and testbench
=======================================

Name: pingpong_unpack_ctrl

Overview:
Ping-pong controller for the 16-bit-in / 8-bit-out direction. It accepts 16-bit words into one of two external mixed-width RAMs (50 x 16 write port, 100 x 8 read port) while the other RAM is drained as a byte stream. It sits between a word-wide producer and a byte-wide consumer in the pingpang design. All logic runs on a single clock.

Parameters:
WR_DEPTH, 50, words per bank; the read depth is 2*WR_DEPTH = 100 bytes.
RD_LAT, 1, external RAM read latency in cycles (registered q); fixed at 1 for this revision.

Ports:
clk_50m  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer has a word.
in_data  input  16  word to store.
in_ready  output  1  block can accept a word this cycle.
ram1_wr_en / ram2_wr_en  output  1  bank write strobe.
ram1_wr_addr / ram2_wr_addr  output  6  word address, 0..49.
ram1_wr_data / ram2_wr_data  output  16  word data; 0 when that bank's wr_en=0.
ram1_rd_en / ram2_rd_en  output  1  bank read strobe.
ram1_rd_addr / ram2_rd_addr  output  7  byte address, 0..99.
ram1_rd_data / ram2_rd_data  input  8  bank read data, valid RD_LAT cycles after rd_en.
data_out  output  8  byte stream.
data_out_valid  output  1  data_out holds a valid byte this cycle.

Behaviour:
- Decided: one clock (clk_50m). Reset rst_n is asynchronous and active-low.
- Reset values: all wr_en/rd_en = 0, all addresses = 0, data_out = 0, data_out_valid = 0, buf_full = 2'b00, wr_sel = bank1, rd_sel = bank1. After reset, in_ready = 1.
- in_ready = !buf_full[wr_sel] (combinational).
- Write side:
  - A transfer occurs when in_valid && in_ready.
  - On a transfer, the selected bank's wr_en = 1, wr_addr = wr_ptr and wr_data = in_data in the same cycle (combinational from the handshake). wr_ptr then increments.
  - On the transfer at wr_ptr = 49: wr_ptr wraps to 0, buf_full[wr_sel] is set, and wr_sel toggles on the next edge.
  - The write address is a 6-bit pointer and never exceeds 49.
- Read FSM, states R_IDLE and R_DRAIN:
  - R_IDLE -> R_DRAIN when buf_full[rd_sel] = 1.
  - In R_DRAIN, the selected bank's rd_en = 1 with rd_addr = 0..99, one byte per cycle, registered outputs.
  - On the cycle issuing rd_addr = 99: buf_full[rd_sel] clears at the next edge and rd_sel toggles.
  - If the other bank is already full at that point, stay in R_DRAIN and issue rd_addr 0 of the other bank on the very next cycle (no bubble). Otherwise go to R_IDLE.
- Byte order: byte address 2k = word k bits [7:0]; byte address 2k+1 = word k bits [15:8].
- Output pipeline:
  - rd_en and the bank select are delayed by RD_LAT+1 cycles.
  - data_out is registered from the selected ramX_rd_data.
  - data_out_valid goes high 2 cycles after the corresponding rd_en.
  - When data_out_valid = 0, data_out = 0.
  - The consumer has no backpressure.
- Simultaneous events:
  - A write fill-complete and a read drain-complete in the same cycle always target different banks; both flags update independently.
  - A write never targets a full bank and a read never targets a non-full bank, so the same bank cannot be both written and read in one cycle.
  - A bank freed at rd_addr = 99 may be written starting the following cycle; the RAM has already sampled the final read address.
- Throughput: input sustains 1 word per 2 cycles indefinitely. Bursts faster than that stall through in_ready.
- Reset mid-operation: both banks are marked empty, partial words and in-flight output bytes are discarded, and data_out_valid drops immediately.
- Any illegal FSM encoding goes to R_IDLE.

Decomposition:
- Shared package pingpang_pkg holds:
  - WR_DEPTH = 50 and RD_DEPTH = 100
  - address widths 6 and 7
  - one-hot read-state constants R_IDLE = 2'b01, R_DRAIN = 2'b10
- One natural sub-module, pp_rd_sequencer: the read FSM, rd_addr counter, rd_sel and the output delay pipeline. The top level keeps the write pointer, buf_full flags and the muxing onto the bank ports.

Test Plan:
1. Reset, then 50 words 16'h0100+k (k = 0..49), one per cycle. Expect: ram1 writes at addr 0..49; buf_full[0] set after k = 49; ram1 drain 0..99 starts the next cycle; bytes out in the order 00,01,01,01,02,01 … 31,01; data_out_valid starts 2 cycles after the first rd_en.
2. Continuous input at 1 word/cycle for 150 words. Expect: in_ready drops after word 100 (both banks full) and rises the cycle after ram1 rd_addr 99; no word is lost or duplicated; the output sequence equals the input split low byte first.
3. Input at 1 word per 2 cycles for 500 words. Expect: in_ready stays 1 throughout; data_out_valid is continuous with no gaps after the first bank fills.
4. Fill ram1 and ram2 back to back before the first drain ends. Expect: ram2 rd_addr 0 issued in the cycle immediately after ram1 rd_addr 99; no valid gap on the output.
5. Assert rst_n = 0 during the ram2 write at addr 20 while ram1 is draining at addr 60. Expect: all outputs at reset values within the same cycle; after release the next word goes to ram1 addr 0.
6. 49 words, then stop. Expect: no rd_en and buf_full = 00. The 50th word arriving 200 cycles later triggers the drain normally.

Source files
------------

// File: rtl/pingpang_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pingpang_pkg
// Brief    : Shared depths, address widths and read-state encoding for the
//            pingpang word-to-byte ping-pong controller.
// Revision : 1.0 - initial release
// ============================================================================
package pingpang_pkg;

  localparam int WR_DEPTH = 50;
  localparam int RD_DEPTH = 2 * WR_DEPTH;
  localparam int WR_AW    = 6;
  localparam int RD_AW    = 7;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t R_IDLE  = 2'b01;
  localparam rd_state_t R_DRAIN = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pp_rd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pp_rd_sequencer
// Brief    : Drains full banks as a byte stream and realigns returned RAM data
//            into a registered output byte with a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module pp_rd_sequencer
  import pingpang_pkg::*;
#(
  parameter int BYTES  = 100,
  parameter int RD_LAT = 1
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [1:0]       buf_full,
  input  logic [7:0]       ram1_rd_data,
  input  logic [7:0]       ram2_rd_data,
  output logic             rd_en,
  output logic             rd_sel,
  output logic             rd_done,
  output logic [RD_AW-1:0] rd_addr,
  output logic [7:0]       data_out,
  output logic             data_out_valid
);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [RD_AW-1:0]  r_rd_addr;
  logic              r_rd_sel;
  logic [RD_LAT-1:0] r_v_pipe;
  logic [RD_LAT-1:0] r_s_pipe;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= w_state_nxt;
  end

  // On the last byte, chain straight into the other bank when it is already full.
  always_comb begin
    w_state_nxt = R_IDLE;
    case (r_state)
      R_IDLE:  w_state_nxt = buf_full[r_rd_sel] ? R_DRAIN : R_IDLE;
      R_DRAIN: begin
        if (rd_done) w_state_nxt = buf_full[!r_rd_sel] ? R_DRAIN : R_IDLE;
        else         w_state_nxt = R_DRAIN;
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (r_state == R_DRAIN);
    rd_done = rd_en && (r_rd_addr == RD_AW'(BYTES - 1));
  end

  assign rd_addr = r_rd_addr;
  assign rd_sel  = r_rd_sel;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_addr      <= '0;
      r_rd_sel       <= 1'b0;
      r_v_pipe       <= '0;
      r_s_pipe       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (rd_done) begin
        r_rd_addr <= '0;
        r_rd_sel  <= !r_rd_sel;
      end else if (rd_en) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
      r_v_pipe[0] <= rd_en;
      r_s_pipe[0] <= r_rd_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        r_v_pipe[i] <= r_v_pipe[i-1];
        r_s_pipe[i] <= r_s_pipe[i-1];
      end
      // RAM q is valid RD_LAT cycles after rd_en; capture it one cycle later.
      data_out       <= r_v_pipe[RD_LAT-1] ?
                        (r_s_pipe[RD_LAT-1] ? ram2_rd_data : ram1_rd_data) : 8'h00;
      data_out_valid <= r_v_pipe[RD_LAT-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pingpong_unpack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_unpack_ctrl
// Brief    : 16-bit-in / 8-bit-out ping-pong controller over two mixed-width
//            RAM banks; write pointer, bank-full flags and bank port muxing.
// Revision : 1.0 - initial release
// ============================================================================
module pingpong_unpack_ctrl #(
  parameter int WR_DEPTH = 50,
  parameter int RD_LAT   = 1
) (
  input  logic                          clk_50m,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [15:0]                   in_data,
  output logic                          in_ready,
  output logic                          ram1_wr_en,
  output logic [pingpang_pkg::WR_AW-1:0] ram1_wr_addr,
  output logic [15:0]                   ram1_wr_data,
  output logic                          ram2_wr_en,
  output logic [pingpang_pkg::WR_AW-1:0] ram2_wr_addr,
  output logic [15:0]                   ram2_wr_data,
  output logic                          ram1_rd_en,
  output logic [pingpang_pkg::RD_AW-1:0] ram1_rd_addr,
  input  logic [7:0]                    ram1_rd_data,
  output logic                          ram2_rd_en,
  output logic [pingpang_pkg::RD_AW-1:0] ram2_rd_addr,
  input  logic [7:0]                    ram2_rd_data,
  output logic [7:0]                    data_out,
  output logic                          data_out_valid
);

  import pingpang_pkg::*;

  logic [WR_AW-1:0] r_wr_ptr;
  logic             r_wr_sel;
  logic [1:0]       r_buf_full;
  logic [1:0]       w_full_nxt;
  logic             w_wr_fire;
  logic             w_wr_last;
  logic             w_rd_en;
  logic             w_rd_sel;
  logic             w_rd_done;
  logic [RD_AW-1:0] w_rd_addr;

  // Gating with rst_n keeps the write strobes quiet while reset is held.
  assign in_ready  = rst_n && !r_buf_full[r_wr_sel];
  assign w_wr_fire = in_valid && in_ready;
  assign w_wr_last = (r_wr_ptr == WR_AW'(WR_DEPTH - 1));

  always_comb begin
    w_full_nxt = r_buf_full;
    if (w_wr_fire && w_wr_last) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_rd_done)              w_full_nxt[w_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_wr_sel   <= 1'b0;
      r_buf_full <= 2'b00;
    end else begin
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_ptr <= '0;
          r_wr_sel <= !r_wr_sel;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      r_buf_full <= w_full_nxt;
    end
  end

  assign ram1_wr_en   = w_wr_fire && !r_wr_sel;
  assign ram2_wr_en   = w_wr_fire &&  r_wr_sel;
  assign ram1_wr_addr = ram1_wr_en ? r_wr_ptr : '0;
  assign ram2_wr_addr = ram2_wr_en ? r_wr_ptr : '0;
  assign ram1_wr_data = ram1_wr_en ? in_data  : '0;
  assign ram2_wr_data = ram2_wr_en ? in_data  : '0;

  assign ram1_rd_en   = w_rd_en && !w_rd_sel;
  assign ram2_rd_en   = w_rd_en &&  w_rd_sel;
  assign ram1_rd_addr = ram1_rd_en ? w_rd_addr : '0;
  assign ram2_rd_addr = ram2_rd_en ? w_rd_addr : '0;

  pp_rd_sequencer #(
    .BYTES  (2 * WR_DEPTH),
    .RD_LAT (RD_LAT)
  ) u_rd_seq (
    .clk_50m        (clk_50m),
    .rst_n          (rst_n),
    .buf_full       (r_buf_full),
    .ram1_rd_data   (ram1_rd_data),
    .ram2_rd_data   (ram2_rd_data),
    .rd_en          (w_rd_en),
    .rd_sel         (w_rd_sel),
    .rd_done        (w_rd_done),
    .rd_addr        (w_rd_addr),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_pingpong_unpack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_unpack_ctrl
// Brief    : Self-checking bench with behavioural RAM banks and a byte-stream
//            scoreboard for pingpong_unpack_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pingpong_unpack_ctrl;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        ram1_wr_en, ram2_wr_en, ram1_rd_en, ram2_rd_en;
  logic [5:0]  ram1_wr_addr, ram2_wr_addr;
  logic [15:0] ram1_wr_data, ram2_wr_data;
  logic [6:0]  ram1_rd_addr, ram2_rd_addr;
  logic [7:0]  ram1_rd_data, ram2_rd_data;
  logic [7:0]  data_out;
  logic        data_out_valid;

  always #10 clk_50m = ~clk_50m;

  pingpong_unpack_ctrl #(.WR_DEPTH(50), .RD_LAT(1)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .ram1_wr_en(ram1_wr_en), .ram1_wr_addr(ram1_wr_addr), .ram1_wr_data(ram1_wr_data),
    .ram2_wr_en(ram2_wr_en), .ram2_wr_addr(ram2_wr_addr), .ram2_wr_data(ram2_wr_data),
    .ram1_rd_en(ram1_rd_en), .ram1_rd_addr(ram1_rd_addr), .ram1_rd_data(ram1_rd_data),
    .ram2_rd_en(ram2_rd_en), .ram2_rd_addr(ram2_rd_addr), .ram2_rd_data(ram2_rd_data),
    .data_out(data_out), .data_out_valid(data_out_valid)
  );

  // Mixed-width banks: 50 x 16 write, 100 x 8 read, registered q.
  logic [15:0] mem1 [50];
  logic [15:0] mem2 [50];
  always @(posedge clk_50m) begin
    if (ram1_wr_en) mem1[ram1_wr_addr] <= ram1_wr_data;
    if (ram2_wr_en) mem2[ram2_wr_addr] <= ram2_wr_data;
    if (ram1_rd_en) ram1_rd_data <= ram1_rd_addr[0] ? mem1[ram1_rd_addr[6:1]][15:8] : mem1[ram1_rd_addr[6:1]][7:0];
    if (ram2_rd_en) ram2_rd_data <= ram2_rd_addr[0] ? mem2[ram2_rd_addr[6:1]][15:8] : mem2[ram2_rd_addr[6:1]][7:0];
  end

  int tests = 0;
  int fails = 0;

  // Reference model: every accepted word lands in bank (n/50)%2 at n%50 and
  // leaves as low byte then high byte; banks drain in fill order, 0..99.
  logic [7:0] exp_q[$];
  int n_acc, exp_rd_addr, exp_rd_bank;
  int cyc = 0;
  int n_out, first_v, last_v, n_rd, first_rd, r1_99, r2_0;
  int n_stall, first_stall_acc, rise_cyc, last_wr;

  task automatic model_reset();
    exp_q.delete();
    n_acc = 0; exp_rd_addr = 0; exp_rd_bank = 0;
  endtask

  task automatic clr_stats();
    n_out = 0; first_v = -1; last_v = -1; n_rd = 0; first_rd = -1;
    r1_99 = -1; r2_0 = -1; n_stall = 0; first_stall_acc = -1; rise_cyc = -1; last_wr = -1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk_50m) begin
    bit ok;
    int eb, ea;
    logic [7:0] eb_byte;
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        eb = (n_acc / 50) % 2;
        ea = n_acc % 50;
        ok = (eb == 0) ?
             (ram1_wr_en && !ram2_wr_en && ram1_wr_addr == 6'(ea) && ram1_wr_data == in_data && ram2_wr_data == 16'h0) :
             (ram2_wr_en && !ram1_wr_en && ram2_wr_addr == 6'(ea) && ram2_wr_data == in_data && ram1_wr_data == 16'h0);
        tests++;
        assert (ok === 1'b1) else begin
          fails++;
          $error("FAIL wr_port word=%0d got en1=%b a1=%0d en2=%b a2=%0d want bank%0d addr %0d",
                 n_acc, ram1_wr_en, ram1_wr_addr, ram2_wr_en, ram2_wr_addr, eb + 1, ea);
        end
        exp_q.push_back(in_data[7:0]);
        exp_q.push_back(in_data[15:8]);
        n_acc++;
        last_wr = cyc;
        if (n_stall > 0 && rise_cyc < 0) rise_cyc = cyc;
      end else begin
        ok = !ram1_wr_en && !ram2_wr_en && ram1_wr_data == 16'h0 && ram2_wr_data == 16'h0;
        tests++;
        assert (ok === 1'b1) else begin
          fails++;
          $error("FAIL wr_idle got en1=%b en2=%b d1=%h d2=%h want all 0", ram1_wr_en, ram2_wr_en, ram1_wr_data, ram2_wr_data);
        end
      end
      if (in_valid && !in_ready) begin
        if (first_stall_acc < 0) first_stall_acc = n_acc;
        n_stall++;
      end
      if (ram1_rd_en || ram2_rd_en) begin
        ok = (exp_rd_bank == 0) ? (ram1_rd_en && !ram2_rd_en && ram1_rd_addr == 7'(exp_rd_addr))
                                : (ram2_rd_en && !ram1_rd_en && ram2_rd_addr == 7'(exp_rd_addr));
        tests++;
        assert (ok === 1'b1) else begin
          fails++;
          $error("FAIL rd_port got en1=%b a1=%0d en2=%b a2=%0d want bank%0d addr %0d",
                 ram1_rd_en, ram1_rd_addr, ram2_rd_en, ram2_rd_addr, exp_rd_bank + 1, exp_rd_addr);
        end
        if (first_rd < 0) first_rd = cyc;
        if (ram1_rd_en && ram1_rd_addr == 7'd99 && r1_99 < 0) r1_99 = cyc;
        if (ram2_rd_en && ram2_rd_addr == 7'd0 && r2_0 < 0) r2_0 = cyc;
        n_rd++;
        exp_rd_addr++;
        if (exp_rd_addr == 100) begin
          exp_rd_addr = 0;
          exp_rd_bank ^= 1;
        end
      end
      if (data_out_valid) begin
        eb_byte = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        assert (data_out === eb_byte) else begin
          fails++;
          $error("FAIL byte_out #%0d got %h want %h", n_out, data_out, eb_byte);
        end
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        n_out++;
      end else begin
        tests++;
        assert (data_out === 8'h00) else begin
          fails++;
          $error("FAIL byte_idle got %h want 00", data_out);
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input int gap);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk_50m);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", 0, 1);
    @(posedge clk_50m); #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk_50m); #1;
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) begin
      @(posedge clk_50m); #1;
    end
    repeat (4) begin
      @(posedge clk_50m); #1;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    bit ok;
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_50m);
    model_reset();
    clr_stats();
    #1 rst_n = 1'b1;
    @(negedge clk_50m);
    ok = in_ready && !ram1_wr_en && !ram2_wr_en && !ram1_rd_en && !ram2_rd_en &&
         ram1_rd_addr == 7'd0 && ram2_rd_addr == 7'd0 && ram1_wr_addr == 6'd0 &&
         ram2_wr_addr == 6'd0 && data_out == 8'h00 && !data_out_valid;
    chk("reset_state", int'(ok), 1);
    @(posedge clk_50m); #1;
  endtask

  initial begin
    bit ok;
    bit hit;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    model_reset();
    clr_stats();

    // 1: single bank fill with a counting pattern
    do_reset();
    for (int k = 0; k < 50; k++) send(16'h0100 + 16'(k), 0);
    wait_drain();
    chk("t1_rd_after_fill", first_rd - last_wr, 2);
    chk("t1_valid_latency", first_v - first_rd, 2);
    chk("t1_bytes", n_out, 100);

    // 2: 150 words back to back, stall until ram1 frees
    do_reset();
    for (int k = 0; k < 150; k++) send(16'($urandom), 0);
    wait_drain();
    chk("t2_stall_after_words", first_stall_acc, 100);
    chk("t2_ready_rise", rise_cyc, r1_99 + 1);
    chk("t2_bytes", n_out, 300);

    // 3: sustained 1 word per 2 cycles
    do_reset();
    for (int k = 0; k < 500; k++) send(16'($urandom), 1);
    wait_drain();
    chk("t3_stalls", n_stall, 0);
    chk("t3_bytes", n_out, 1000);
    chk("t3_contiguous", last_v - first_v + 1, 1000);

    // 4: both banks full before the first drain ends
    do_reset();
    for (int k = 0; k < 100; k++) send(16'($urandom), 0);
    wait_drain();
    chk("t4_no_bubble", r2_0, r1_99 + 1);
    chk("t4_contiguous", last_v - first_v + 1, 200);
    chk("t4_bytes", n_out, 200);

    // 5: reset during ram2 write 20 while ram1 reads 60
    do_reset();
    for (int k = 0; k < 70; k++) send(16'($urandom), 0);
    hit = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_50m);
      if (ram1_rd_en && ram1_rd_addr == 7'd59) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t5_reach_addr59", int'(hit), 1);
    @(posedge clk_50m); #1;
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    @(negedge clk_50m); #1;
    ok = ram2_wr_en && ram2_wr_addr == 6'd20 && ram1_rd_en && ram1_rd_addr == 7'd60;
    chk("t5_collision_point", int'(ok), 1);
    rst_n = 1'b0;
    #1;
    ok = !ram1_wr_en && !ram2_wr_en && !ram1_rd_en && !ram2_rd_en &&
         ram1_wr_addr == 6'd0 && ram2_wr_addr == 6'd0 && ram1_rd_addr == 7'd0 &&
         ram2_rd_addr == 7'd0 && ram1_wr_data == 16'h0 && ram2_wr_data == 16'h0 &&
         data_out == 8'h00 && !data_out_valid;
    chk("t5_async_reset_outputs", int'(ok), 1);
    in_valid = 1'b0;
    do_reset();
    for (int k = 0; k < 50; k++) send(16'($urandom), 0);
    wait_drain();
    chk("t5_bytes_after_reset", n_out, 100);

    // 6: partial bank never drains until its last word
    do_reset();
    for (int k = 0; k < 49; k++) send(16'($urandom), int'($urandom_range(0, 3)));
    repeat (200) begin
      @(posedge clk_50m); #1;
    end
    chk("t6_no_read", n_rd, 0);
    chk("t6_ready_high", int'(in_ready), 1);
    send(16'($urandom), 0);
    wait_drain();
    chk("t6_rd_after_fill", first_rd - last_wr, 2);
    chk("t6_bytes", n_out, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
